// File: rtl/psram_cmd_split.sv
// Splits linear byte-range requests into PSRAM sub-commands that never cross a
// page boundary and never exceed MAX_BURST bytes.
module psram_cmd_split #(
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 12,
   parameter int ID_WIDTH   = 4,
   parameter int PAGE_SIZE  = 1024,
   parameter int MAX_BURST  = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [LEN_WIDTH-1:0]  req_len_i,
   input  logic                  req_write_i,
   input  logic [ID_WIDTH-1:0]   req_id_i,
   output logic                  sub_valid_o,
   input  logic                  sub_ready_i,
   output logic [ADDR_WIDTH-1:0] sub_addr_o,
   output logic [LEN_WIDTH-1:0]  sub_len_o,
   output logic                  sub_write_o,
   output logic [ID_WIDTH-1:0]   sub_id_o,
   output logic                  sub_first_o,
   output logic                  sub_last_o,
   output logic                  busy_o
);

   localparam int PG_BITS = $clog2(PAGE_SIZE);
   localparam int CW      = LEN_WIDTH + 1;

   typedef enum logic {IDLE, SPLIT} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         rem_q;
   logic [CW-1:0]         chunk_q;
   logic                  req_hs, sub_hs;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [CW-1:0]         ld_rem;
   logic [CW-1:0]         ld_chunk;

   // Bytes issuable from a given page offset: min(remaining, to-page-end, MAX_BURST).
   function automatic logic [CW-1:0] calc_chunk(input logic [PG_BITS-1:0] off,
                                                input logic [CW-1:0] rem);
      logic [31:0] c;
      logic [31:0] to_page;
      to_page = 32'(PAGE_SIZE) - 32'(off);
      c = 32'(rem);
      if (to_page < c) c = to_page;
      if (32'(MAX_BURST) < c) c = 32'(MAX_BURST);
      return CW'(c);
   endfunction

   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign req_hs      = req_valid_i && req_ready_o;
   assign sub_hs      = sub_valid_o && sub_ready_i;
   assign busy_o      = (state_q != IDLE);

   // Next sub-command source: a fresh request in IDLE, otherwise the remainder.
   always_comb begin
      ld_addr  = sub_addr_o + ADDR_WIDTH'(chunk_q);
      ld_rem   = rem_q - chunk_q;
      if (state_q == IDLE) begin
         ld_addr = req_addr_i;
         ld_rem  = {1'b0, req_len_i} + CW'(1);
      end
      ld_chunk = calc_chunk(ld_addr[PG_BITS-1:0], ld_rem);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_hs) state_d = SPLIT;
         SPLIT:   if (sub_hs && sub_last_o) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sub_valid_o <= 1'b0;
         sub_addr_o  <= '0;
         sub_len_o   <= '0;
         sub_write_o <= 1'b0;
         sub_id_o    <= '0;
         sub_first_o <= 1'b0;
         sub_last_o  <= 1'b0;
         rem_q       <= '0;
         chunk_q     <= '0;
      end else if (req_hs || (sub_hs && !sub_last_o)) begin
         sub_valid_o <= 1'b1;
         sub_addr_o  <= ld_addr;
         sub_len_o   <= LEN_WIDTH'(ld_chunk - CW'(1));
         sub_first_o <= req_hs;
         sub_last_o  <= (ld_chunk == ld_rem);
         rem_q       <= ld_rem;
         chunk_q     <= ld_chunk;
         if (req_hs) begin
            sub_write_o <= req_write_i;
            sub_id_o    <= req_id_i;
         end
      end else if (sub_hs) begin
         sub_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psram_cmd_split.sv
// Randomized self-checking bench for psram_cmd_split against a queue-based
// split model built from the page/burst rules.
module tb_psram_cmd_split;

   typedef struct packed {
      logic [31:0] addr;
      logic [11:0] len;
      logic        first;
      logic        last;
      logic [3:0]  id;
      logic        wr;
   } sub_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [11:0] req_len;
   logic        req_write;
   logic [3:0]  req_id;
   logic        sub_valid;
   logic        sub_ready;
   logic [31:0] sub_addr;
   logic [11:0] sub_len;
   logic        sub_write;
   logic [3:0]  sub_id;
   logic        sub_first;
   logic        sub_last;
   logic        busy;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   sub_t exp_q[$];
   sub_t obs_q[$];
   int   obs_cyc[$];

   psram_cmd_split dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
      .req_len_i(req_len), .req_write_i(req_write), .req_id_i(req_id),
      .sub_valid_o(sub_valid), .sub_ready_i(sub_ready), .sub_addr_o(sub_addr),
      .sub_len_o(sub_len), .sub_write_o(sub_write), .sub_id_o(sub_id),
      .sub_first_o(sub_first), .sub_last_o(sub_last), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every sub-command that will be accepted on the coming edge.
   always @(negedge clk)
      if (!rst && sub_valid && sub_ready) begin
         obs_q.push_back('{sub_addr, sub_len, sub_first, sub_last, sub_id, sub_write});
         obs_cyc.push_back(cyc);
      end

   // Reference split: walk the byte range, cutting at page ends and burst limit.
   task automatic build_exp(input logic [31:0] addr, input int len, input logic wr,
                            input logic [3:0] id);
      logic [31:0] a;
      int r, c, tp;
      logic f;
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      a = addr; r = len + 1; f = 1'b1;
      while (r > 0) begin
         tp = 1024 - int'(a % 32'd1024);
         c  = r;
         if (tp < c) c = tp;
         if (256 < c) c = 256;
         exp_q.push_back('{addr: a, len: 12'(c - 1), first: f, last: (c == r), id: id, wr: wr});
         a = a + 32'(c);
         r = r - c;
         f = 1'b0;
      end
   endtask

   task automatic drive_req(input logic [31:0] addr, input int len, input logic wr,
                            input logic [3:0] id, output bit to);
      to = 1'b1;
      req_valid = 1'b1; req_addr = addr; req_len = 12'(len); req_write = wr; req_id = id;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (req_ready) begin to = 1'b0; break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_subs(input bit rnd, output bit to);
      to = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         if (obs_q.size() >= exp_q.size()) begin to = 1'b0; break; end
         @(posedge clk); #1;
         if (rnd) sub_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req_valid = 1'b0; sub_ready = 1'b0;
      req_addr = '0; req_len = '0; req_write = 1'b0; req_id = '0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({sub_valid, busy, req_ready, sub_first, sub_last} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got v/b/r/f/l=%b required 00000",
                  {sub_valid, busy, req_ready, sub_first, sub_last});
      end
      n_checks++;
      if ({sub_addr, sub_len, sub_id, sub_write} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h len=%h id=%h wr=%b required all zero",
                  sub_addr, sub_len, sub_id, sub_write);
      end
      rst = 1'b0; #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b required 1", req_ready);
      end
   endtask

   task automatic test_single;
      bit to;
      sub_ready = 1'b1;
      build_exp(32'h000, 255, 1'b1, 4'd3);
      drive_req(32'h000, 255, 1'b1, 4'd3, to);
      n_checks++;
      if (to || sub_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: got valid=%b timeout=%0d required valid=1", sub_valid, to);
      end
      wait_subs(1'b0, to);
      n_checks++;
      if (to || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
         n_fail++;
         $display("FAIL single_sub: got n=%0d %h required n=1 %h", obs_q.size(), obs_q[0], exp_q[0]);
      end
      n_checks++;
      if (sub_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_done: got v=%b r=%b b=%b required 0 1 0", sub_valid, req_ready, busy);
      end
   endtask

   task automatic test_page_cross;
      bit to;
      sub_ready = 1'b1;
      build_exp(32'h3F0, 31, 1'b0, 4'd5);
      drive_req(32'h3F0, 31, 1'b0, 4'd5, to);
      wait_subs(1'b0, to);
      n_checks++;
      if (to || obs_q.size() != 2) begin
         n_fail++;
         $display("FAIL page_count: got %0d required 2", obs_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL page_sub%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (obs_cyc.size() < 2 || obs_cyc[1] != obs_cyc[0] + 1) begin
         n_fail++;
         $display("FAIL page_b2b: got gap cycles %0d required 1",
                  obs_cyc.size() < 2 ? -1 : obs_cyc[1] - obs_cyc[0]);
      end
      n_checks++;
      if (req_ready !== 1'b1 || sub_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL page_ready_after: got r=%b v=%b required 1 0", req_ready, sub_valid);
      end
   endtask

   task automatic test_max_burst;
      bit to;
      sub_ready = 1'b1;
      build_exp(32'h100, 1023, 1'b1, 4'd9);
      drive_req(32'h100, 1023, 1'b1, 4'd9, to);
      wait_subs(1'b0, to);
      n_checks++;
      if (to || obs_q.size() != 4) begin
         n_fail++;
         $display("FAIL burst_count: got %0d required 4", obs_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL burst_sub%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      bit   to;
      sub_t snap;
      sub_ready = 1'b0;
      build_exp(32'h3F0, 31, 1'b1, 4'd7);
      drive_req(32'h3F0, 31, 1'b1, 4'd7, to);
      snap = '{sub_addr, sub_len, sub_first, sub_last, sub_id, sub_write};
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (sub_valid !== 1'b1 || {sub_addr, sub_len, sub_first, sub_last, sub_id, sub_write} !== snap
             || snap !== exp_q[0]) begin
            n_fail++;
            $display("FAIL bp_stable%0d: got v=%b %h required v=1 %h", i, sub_valid,
                     {sub_addr, sub_len, sub_first, sub_last, sub_id, sub_write}, exp_q[0]);
         end
      end
      sub_ready = 1'b1;
      wait_subs(1'b0, to);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (to || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
         n_fail++;
         $display("FAIL bp_seq: got n=%0d %h %h required n=2 %h %h", obs_q.size(),
                  obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
      end
   endtask

   task automatic test_wrap;
      bit to;
      sub_ready = 1'b1;
      build_exp(32'hFFFF_FFF8, 15, 1'b0, 4'd2);
      drive_req(32'hFFFF_FFF8, 15, 1'b0, 4'd2, to);
      wait_subs(1'b0, to);
      n_checks++;
      if (to || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]
          || exp_q[1].addr !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap: got n=%0d %h %h required n=2 %h %h", obs_q.size(),
                  obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
      end
   endtask

   task automatic test_full_len;
      bit to;
      sub_ready = 1'b1;
      build_exp(32'h0000_2000, 4095, 1'b1, 4'd15);
      drive_req(32'h0000_2000, 4095, 1'b1, 4'd15, to);
      wait_subs(1'b0, to);
      n_checks++;
      if (to || obs_q.size() != 16) begin
         n_fail++;
         $display("FAIL full_count: got %0d required 16", obs_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL full_sub%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit to;
      sub_ready = 1'b0;
      build_exp(32'h100, 1023, 1'b1, 4'd4);
      drive_req(32'h100, 1023, 1'b1, 4'd4, to);
      sub_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      sub_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (sub_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_hold: got v=%b b=%b r=%b required 0 0 0", sub_valid, busy, req_ready);
      end
      n_checks++;
      if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
         n_fail++;
         $display("FAIL rstmid_issued: got n=%0d %h %h required n=2 %h %h", obs_q.size(),
                  obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
      end
      rst = 1'b0; #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_ready: got %b required 1", req_ready);
      end
      sub_ready = 1'b1;
      build_exp(32'h3F8, 19, 1'b0, 4'd6);
      drive_req(32'h3F8, 19, 1'b0, 4'd6, to);
      wait_subs(1'b0, to);
      for (int i = 0; i < exp_q.size(); i++) begin
         n_checks++;
         if (to || obs_q[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL rstmid_fresh%0d: got %h required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_random;
      bit          to;
      logic [31:0] a;
      int          len;
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       a[9:0] = 10'(1024 - $urandom_range(1, 40));
            1:       a = 32'hFFFF_FFFF - 32'($urandom_range(0, 600));
            2:       a[7:0] = 8'h00;
            default: ;
         endcase
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 600);
         if (t == 0) len = 0;
         sub_ready = 1'($urandom_range(0, 1));
         build_exp(a, len, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         drive_req(a, len, exp_q[0].wr, exp_q[0].id, to);
         wait_subs(1'b1, to);
         n_checks++;
         if (to || obs_q.size() != exp_q.size() || obs_q != exp_q) begin
            n_fail++;
            $display("FAIL rand%0d addr=%h len=%0d: got n=%0d first=%h required n=%0d first=%h",
                     t, a, len, obs_q.size(), obs_q[0], exp_q.size(), exp_q[0]);
         end
         n_checks++;
         if (sub_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rand%0d_done: got v=%b r=%b required 0 1", t, sub_valid, req_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_page_cross();
      test_max_burst();
      test_backpressure();
      test_wrap();
      test_full_len();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
